// File: rtl/gpu_pkg.sv
// Shared register map, control/status bit positions and default 640x480 timing
// for the GPU video timing core.
package gpu_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_IRQ_LO = 4'd2;
  localparam logic [3:0] ADDR_IRQ_HI = 4'd3;
  localparam logic [3:0] ADDR_SL_LO  = 4'd4;
  localparam logic [3:0] ADDR_SL_HI  = 4'd5;
  localparam logic [3:0] ADDR_FC_LO  = 4'd6;
  localparam logic [3:0] ADDR_FC_HI  = 4'd7;

  localparam int CTRL_VBLANK_IE = 0;
  localparam int CTRL_LINE_IE   = 1;
  localparam int CTRL_RUN       = 2;
  localparam int STAT_VBLANK    = 0;
  localparam int STAT_LINE      = 1;

  localparam logic [2:0] CTRL_RESET = 3'b100;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

endpackage

// File: rtl/bus_strobe_sync.sv
// Brings the asynchronous CPU strobe into the pixel clock domain and emits a
// one-clock pulse on its rising edge.
module bus_strobe_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_strobe,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_strobe;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_sync3;

endmodule

// File: rtl/video_timing_ctrl.sv
// Parametrised VGA timing core with CPU register port and level IRQ.
// Optional 16-bit frame counter at regs 6/7 when VTC_FRAME_COUNTER_EN is defined.
module video_timing_ctrl
  import gpu_pkg::*;
#(
  parameter int DIVISION  = 2,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int CW       = $clog2(H_TOTAL),
  localparam int SW       = $clog2(V_TOTAL)
) (
  input  logic          CLK100MHz,
  input  logic          rst,
  input  logic [7:0]    data,
  input  logic [3:0]    addr,
  input  logic          rw,
  input  logic          cs_clock,
  output logic [7:0]    data_out,
  output logic          pixel_tick,
  output logic [CW-1:0] cycle,
  output logic [SW-1:0] scanline,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank,
  output logic          frame_start,
  output logic          irq
);

  localparam int DW = (DIVISION > 1) ? $clog2(DIVISION) : 1;
  localparam int CX = CW + 1;
  localparam int SX = SW + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVISION - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [SW-1:0] V_LAST   = SW'(V_TOTAL - 1);
  localparam logic [CX-1:0] H_VIS    = CX'(H_VISIBLE);
  localparam logic [CX-1:0] HS_BEG   = CX'(H_VISIBLE + H_FRONT);
  localparam logic [CX-1:0] HS_END   = CX'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [SX-1:0] V_VIS    = SX'(V_VISIBLE);
  localparam logic [SX-1:0] VS_BEG   = SX'(V_VISIBLE + V_FRONT);
  localparam logic [SX-1:0] VS_END   = SX'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [2:0]    r_ctrl;
  logic [1:0]    r_pend;
  logic [15:0]   r_irq_line;
  logic [7:0]    r_sl_shadow;
  logic [7:0]    r_data_out;
  logic          r_irq;
  logic [DW-1:0] r_div;
  logic          r_tick;
  logic [CW-1:0] r_cycle;
  logic [SW-1:0] r_scanline;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic          r_frame_start;

  logic          w_acc;
  logic          w_wr;
  logic          w_rd;
  logic          w_run;
  logic [DW-1:0] w_div_nxt;
  logic          w_tick_nxt;
  logic [CW-1:0] w_cyc_nxt;
  logic [SW-1:0] w_sl_nxt;
  logic          w_wrap;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_blank_nxt;
  logic          w_frame_nxt;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;
  logic [15:0]   w_sl16;
  logic [7:0]    w_rdata;

  bus_strobe_sync u_strobe (
    .i_clk    (CLK100MHz),
    .i_rst    (rst),
    .i_strobe (cs_clock),
    .o_pulse  (w_acc)
  );

  assign w_wr   = w_acc & ~rw;
  assign w_rd   = w_acc & rw;
  assign w_run  = r_ctrl[CTRL_RUN];
  assign w_sl16 = 16'(r_scanline);

  // Next-state timing; registering these keeps sync/blank aligned with the counters.
  always_comb begin
    w_div_nxt = '0;
    if (w_run && (r_div != DIV_LAST))
      w_div_nxt = r_div + 1'b1;
    w_tick_nxt = w_run && (w_div_nxt == DIV_LAST);

    w_cyc_nxt = r_cycle;
    w_sl_nxt  = r_scanline;
    w_wrap    = 1'b0;
    if (!w_run) begin
      w_cyc_nxt = '0;
      w_sl_nxt  = '0;
    end else if (r_tick) begin
      if (r_cycle == H_LAST) begin
        w_wrap    = 1'b1;
        w_cyc_nxt = '0;
        w_sl_nxt  = (r_scanline == V_LAST) ? '0 : r_scanline + 1'b1;
      end else begin
        w_cyc_nxt = r_cycle + 1'b1;
      end
    end

    w_hs_act    = w_run && ({1'b0, w_cyc_nxt} >= HS_BEG) && ({1'b0, w_cyc_nxt} < HS_END);
    w_vs_act    = w_run && ({1'b0, w_sl_nxt} >= VS_BEG) && ({1'b0, w_sl_nxt} < VS_END);
    w_blank_nxt = !w_run || ({1'b0, w_cyc_nxt} >= H_VIS) || ({1'b0, w_sl_nxt} >= V_VIS);
    w_frame_nxt = w_wrap && (w_sl_nxt == '0);

    w_set = '0;
    w_set[STAT_VBLANK] = w_wrap && ({1'b0, w_sl_nxt} == V_VIS);
    w_set[STAT_LINE]   = w_wrap && (16'(w_sl_nxt) == r_irq_line);
    w_clr = (w_wr && (addr == ADDR_STATUS)) ? data[1:0] : 2'b00;
  end

  always_ff @(posedge CLK100MHz or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      r_tick        <= 1'b0;
      r_cycle       <= '0;
      r_scanline    <= '0;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_tick        <= w_tick_nxt;
      r_cycle       <= w_cyc_nxt;
      r_scanline    <= w_sl_nxt;
      r_hs          <= w_hs_act ? HS_POL : ~HS_POL;
      r_vs          <= w_vs_act ? VS_POL : ~VS_POL;
      r_blank       <= w_blank_nxt;
      r_frame_start <= w_frame_nxt;
    end
  end

`ifdef VTC_FRAME_COUNTER_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_fc_shadow;

  always_ff @(posedge CLK100MHz or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_fc_shadow <= '0;
    end else begin
      if (w_wr && (addr == ADDR_FC_LO))
        r_frame_cnt <= '0;
      else if (r_frame_start)
        r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_rd && (addr == ADDR_FC_LO))
        r_fc_shadow <= r_frame_cnt[15:8];
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (addr)
      ADDR_CTRL:   w_rdata = {5'b0, r_ctrl};
      ADDR_STATUS: w_rdata = {6'b0, r_pend};
      ADDR_IRQ_LO: w_rdata = r_irq_line[7:0];
      ADDR_IRQ_HI: w_rdata = r_irq_line[15:8];
      ADDR_SL_LO:  w_rdata = w_sl16[7:0];
      ADDR_SL_HI:  w_rdata = r_sl_shadow;
`ifdef VTC_FRAME_COUNTER_EN
      ADDR_FC_LO:  w_rdata = r_frame_cnt[7:0];
      ADDR_FC_HI:  w_rdata = r_fc_shadow;
`endif
      default:     w_rdata = '0;
    endcase
  end

  // A hardware set and a CPU clear landing on the same edge resolve to set.
  always_ff @(posedge CLK100MHz or posedge rst) begin
    if (rst) begin
      r_ctrl      <= CTRL_RESET;
      r_irq_line  <= '0;
      r_pend      <= '0;
      r_irq       <= 1'b0;
      r_data_out  <= '0;
      r_sl_shadow <= '0;
    end else begin
      if (w_wr) begin
        case (addr)
          ADDR_CTRL:   r_ctrl           <= data[2:0];
          ADDR_IRQ_LO: r_irq_line[7:0]  <= data;
          ADDR_IRQ_HI: r_irq_line[15:8] <= data;
          default:     ;
        endcase
      end
      r_pend <= (r_pend & ~w_clr) | w_set;
      r_irq  <= |(r_pend & {r_ctrl[CTRL_LINE_IE], r_ctrl[CTRL_VBLANK_IE]});
      if (w_rd) begin
        r_data_out <= w_rdata;
        if (addr == ADDR_SL_LO)
          r_sl_shadow <= w_sl16[15:8];
      end
    end
  end

  assign data_out    = r_data_out;
  assign pixel_tick  = r_tick;
  assign cycle       = r_cycle;
  assign scanline    = r_scanline;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank   = r_blank;
  assign frame_start = r_frame_start;
  assign irq         = r_irq;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl using a 12x7 timing with DIVISION=2.
module tb_video_timing_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic [3:0] addr;
  logic       rw;
  logic       cs;
  logic [7:0] data_out;
  logic       pixel_tick;
  logic [3:0] cycle;
  logic [2:0] scanline;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank;
  logic       frame_start;
  logic       irq;

  int total = 0;
  int bad   = 0;
  int n, ec, es;
  bit seen;

  always #5 clk = ~clk;

  video_timing_ctrl #(
    .DIVISION(2), .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .CLK100MHz(clk), .rst(rst), .data(data), .addr(addr), .rw(rw),
    .cs_clock(cs), .data_out(data_out), .pixel_tick(pixel_tick),
    .cycle(cycle), .scanline(scanline), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank(vga_blank), .frame_start(frame_start), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [3:0] a, input logic [7:0] d, input logic r);
    addr = a;
    data = d;
    rw   = r;
    @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pos(input int c, input int s, input bit need_tick, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (int'(cycle) == c && int'(scanline) == s && (!need_tick || pixel_tick))
        found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_fs(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (frame_start) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tick"}, 32'(pixel_tick), 32'd0);
    check({tag, "_cycle"}, 32'(cycle), 32'd0);
    check({tag, "_scanline"}, 32'(scanline), 32'd0);
    check({tag, "_blank"}, 32'(vga_blank), 32'd1);
    check({tag, "_hs"}, 32'(vga_hs), 32'd1);
    check({tag, "_vs"}, 32'(vga_vs), 32'd1);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
    check({tag, "_dout"}, 32'(data_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    cs   = 1'b0;
    data = 8'h00;
    addr = 4'h0;
    rw   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Test 1: two frames of free-running timing after reset release.
    rst = 1'b0;
    for (int k = 1; k <= 340; k++) begin
      if (k > 1) @(negedge clk);
      n  = (k - 1) / 2;
      ec = n % 12;
      es = (n / 12) % 7;
      check("t1_tick", 32'(pixel_tick), 32'(k % 2 == 0));
      check("t1_cycle", 32'(cycle), 32'(ec));
      check("t1_scanline", 32'(scanline), 32'(es));
      check("t1_hs", 32'(vga_hs), 32'(!(ec == 9 || ec == 10)));
      check("t1_vs", 32'(vga_vs), 32'(es != 5));
      check("t1_blank", 32'(vga_blank), 32'((k == 1) || ec >= 8 || es >= 4));
      check("t1_fs", 32'(frame_start), 32'((k % 2 == 1) && n > 0 && n % 84 == 0));
    end

    // Test 2: vblank interrupt and W1C.
    wait_fs("t2_fs_seen");
    bus(4'd1, 8'h03, 1'b0);
    bus(4'd0, 8'h05, 1'b0);
    check("t2_irq_idle", 32'(irq), 32'd0);
    wait_pos(0, 4, 1'b0, "t2_reach_vblank");
    check("t2_irq_same_clk", 32'(irq), 32'd0);
    @(negedge clk);
    check("t2_irq_next_clk", 32'(irq), 32'd1);
    bus(4'd1, 8'h00, 1'b1);
    check("t2_status", 32'(data_out), 32'h01);
    bus(4'd1, 8'h01, 1'b0);
    check("t2_irq_cleared", 32'(irq), 32'd0);

    // Test 3: line-match interrupt, scanline readback, out-of-range line.
    bus(4'd2, 8'h02, 1'b0);
    bus(4'd3, 8'h00, 1'b0);
    bus(4'd1, 8'h03, 1'b0);
    bus(4'd0, 8'h06, 1'b0);
    check("t3_irq_idle", 32'(irq), 32'd0);
    wait_pos(0, 2, 1'b0, "t3_reach_line2");
    check("t3_irq_same_clk", 32'(irq), 32'd0);
    @(negedge clk);
    check("t3_irq_next_clk", 32'(irq), 32'd1);
    bus(4'd4, 8'h00, 1'b1);
    check("t3_scanline_lo", 32'(data_out), 32'h02);
    bus(4'd5, 8'h00, 1'b1);
    check("t3_scanline_hi", 32'(data_out), 32'h00);
    bus(4'd1, 8'h00, 1'b1);
    check("t3_status_line", 32'(data_out), 32'h02);
    bus(4'd1, 8'h03, 1'b0);
    bus(4'd2, 8'h09, 1'b0);
    check("t3_irq_after_clear", 32'(irq), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 340; i++) begin
      @(negedge clk);
      if (irq) seen = 1'b1;
    end
    check("t3_line9_no_irq", 32'(seen), 32'd0);
    bus(4'd1, 8'h00, 1'b1);
    check("t3_line9_no_pend", 32'(data_out & 8'h02), 32'd0);

    // Test 4: W1C lands on the same edge as the vblank set.
    wait_pos(0, 0, 1'b0, "t4_reach_frame");
    bus(4'd1, 8'h03, 1'b0);
    bus(4'd0, 8'h05, 1'b0);
    check("t4_irq_idle", 32'(irq), 32'd0);
    wait_pos(10, 3, 1'b1, "t4_reach_c10_l3");
    addr = 4'd1;
    data = 8'h01;
    rw   = 1'b0;
    cs   = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_set_wins_irq", 32'(irq), 32'd1);
    bus(4'd1, 8'h00, 1'b1);
    check("t4_set_wins_status", 32'(data_out), 32'h01);

    // Test 5: stop mid-line, then restart with full divider delay.
    bus(4'd1, 8'h03, 1'b0);
    wait_pos(5, 1, 1'b0, "t5_reach_mid");
    bus(4'd0, 8'h00, 1'b0);
    check("t5_cycle", 32'(cycle), 32'd0);
    check("t5_scanline", 32'(scanline), 32'd0);
    check("t5_blank", 32'(vga_blank), 32'd1);
    check("t5_tick", 32'(pixel_tick), 32'd0);
    check("t5_hs", 32'(vga_hs), 32'd1);
    check("t5_irq", 32'(irq), 32'd0);
    addr = 4'd0;
    data = 8'h04;
    rw   = 1'b0;
    cs   = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_tick_before_run", 32'(pixel_tick), 32'd0);
    @(negedge clk);
    check("t5_tick_run_clk1", 32'(pixel_tick), 32'd0);
    check("t5_cycle_run_clk1", 32'(cycle), 32'd0);
    @(negedge clk);
    check("t5_tick_run_clk2", 32'(pixel_tick), 32'd1);
    check("t5_blank_run_clk2", 32'(vga_blank), 32'd0);
    @(negedge clk);
    check("t5_tick_run_clk3", 32'(pixel_tick), 32'd0);
    check("t5_cycle_run_clk3", 32'(cycle), 32'd1);
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);

    // Test 6: asynchronous reset mid-frame.
    repeat (30) @(negedge clk);
    bus(4'd0, 8'h00, 1'b1);
    check("t6_ctrl_before", 32'(data_out), 32'h04);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    rst = 1'b0;
    bus(4'd0, 8'h00, 1'b1);
    check("t6_ctrl_reset", 32'(data_out), 32'h04);
    bus(4'd2, 8'h00, 1'b1);
    check("t6_irq_line_reset", 32'(data_out), 32'h00);
`ifdef VTC_FRAME_COUNTER_EN
    wait_fs("t6_fc_frame1");
    wait_fs("t6_fc_frame2");
    wait_fs("t6_fc_frame3");
    bus(4'd6, 8'h00, 1'b1);
    check("t6_fc_lo", 32'(data_out), 32'h03);
    bus(4'd7, 8'h00, 1'b1);
    check("t6_fc_hi", 32'(data_out), 32'h00);
`else
    bus(4'd6, 8'h00, 1'b1);
    check("t6_reg6_zero", 32'(data_out), 32'h00);
    bus(4'd7, 8'h00, 1'b1);
    check("t6_reg7_zero", 32'(data_out), 32'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
